pwm: RTL and testbench



---
 rtl/pwm.sv | 70 +++++++
 tb/tb_pwm.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm.sv
// ---------------------------------------------------------------------------
// pwm -- fixed-period, edge-aligned pulse-width modulator.
//
// A free-running counter defines a period of PERIOD clocks. The output is
// high for the first PW clocks of each period. PW is sampled only on the
// clock where the counter is zero, so a width change never truncates or
// glitches the pulse in progress.
//
// Parameters:
//   WIDTH  - width of PW, the counter and the duty register (default 12)
//   PERIOD - clocks per period, legal range 2..2**WIDTH (default 4096)
//   INVERT - 1 inverts PWM and its reset level; period_start unaffected
//
// Ports:
//   clk          - single clock, rising-edge active
//   rst          - synchronous, active-high reset
//   PW           - requested high time in clocks; only looked at when the
//                  counter is zero, don't-care otherwise
//   PWM          - registered PWM waveform
//   period_start - registered one-clock strobe on the first clock of a period
//
// There are no handshakes on this block: PW is a level input sampled once per
// period, and both outputs are plain registered levels.
// ---------------------------------------------------------------------------
module pwm #(
  parameter int WIDTH  = 12,
  parameter int PERIOD = 4096,
  parameter int INVERT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PW,
  output logic             PWM,
  output logic             period_start
);

  // Terminal count. When PERIOD == 2**WIDTH this is all ones, so the wrap
  // to zero coincides with natural overflow.
  localparam logic [WIDTH-1:0] last_cnt = WIDTH'(PERIOD - 1);
  localparam logic             idle_lvl = (INVERT != 0);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] duty_eff;
  logic             at_start;

  // At the period boundary the incoming PW is used directly so the very
  // first clock of the period already reflects the new width; for the rest
  // of the period the held copy is used and PW is ignored.
  assign at_start = (cnt == '0);
  assign duty_eff = at_start ? PW : duty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      duty_q       <= '0;
      PWM          <= idle_lvl;
      period_start <= 1'b0;
    end else begin
      duty_q       <= duty_eff;
      // Compare uses the count before increment, so the output register
      // reflects the count value just consumed. PW >= PERIOD never fails
      // this compare, which gives a saturated, always-high period.
      PWM          <= (cnt < duty_eff) ^ idle_lvl;
      period_start <= at_start;
      cnt          <= (cnt == last_cnt) ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pwm.sv
// ---------------------------------------------------------------------------
// tb_pwm -- bench for pwm. Three instances share one clock:
//   0: default parameters, 1: PERIOD=100, 2: INVERT=1.
// A reference model predicts every output from the number of clocks elapsed
// since reset release; per-period high time and period length are also
// measured and pinned against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pwm;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic [11:0] pw_a = 12'd25, pw_b = 12'd150, pw_c = 12'd25;
  logic        pwm_a, pwm_b, pwm_c;
  logic        ps_a, ps_b, ps_c;

  pwm u_a (.clk(clk), .rst(rst_a), .PW(pw_a), .PWM(pwm_a), .period_start(ps_a));
  pwm #(.WIDTH(12), .PERIOD(100), .INVERT(0))
    u_b (.clk(clk), .rst(rst_b), .PW(pw_b), .PWM(pwm_b), .period_start(ps_b));
  pwm #(.WIDTH(12), .PERIOD(4096), .INVERT(1))
    u_c (.clk(clk), .rst(rst_c), .PW(pw_c), .PWM(pwm_c), .period_start(ps_c));

  logic        rst_v[3];
  logic [11:0] pw_v[3];
  logic        pwm_v[3];
  logic        ps_v[3];
  assign rst_v[0] = rst_a;  assign rst_v[1] = rst_b;  assign rst_v[2] = rst_c;
  assign pw_v[0]  = pw_a;   assign pw_v[1]  = pw_b;   assign pw_v[2]  = pw_c;
  assign pwm_v[0] = pwm_a;  assign pwm_v[1] = pwm_b;  assign pwm_v[2] = pwm_c;
  assign ps_v[0]  = ps_a;   assign ps_v[1]  = ps_b;   assign ps_v[2]  = ps_c;

  function automatic int per_of(int i);
    return (i == 1) ? 100 : 4096;
  endfunction

  function automatic bit inv_of(int i);
    return (i == 2);
  endfunction

  // ---------------- scoreboard counters ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(string name, int idx, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s[dut%0d] t=%0t got %0d expected %0d", name, idx, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Output after the k-th edge since release is (k mod PERIOD < duty) where
  // duty is PW as seen at the most recent multiple-of-PERIOD edge.
  bit model_ok = 1'b0;
  bit exp_pwm[3];
  bit exp_ps[3];
  int n_e[3];
  int duty[3];

  always @(posedge clk) begin
    model_ok <= 1'b1;
    for (int i = 0; i < 3; i++) begin
      automatic int pos;
      automatic int dnew;
      if (rst_v[i]) begin
        n_e[i]     <= 0;
        exp_pwm[i] <= inv_of(i);
        exp_ps[i]  <= 1'b0;
      end else begin
        pos        = n_e[i] % per_of(i);
        dnew       = (pos == 0) ? int'(pw_v[i]) : duty[i];
        duty[i]    <= dnew;
        exp_pwm[i] <= (pos < dnew) ^ inv_of(i);
        exp_ps[i]  <= (pos == 0);
        n_e[i]     <= n_e[i] + 1;
      end
    end
  end

  // ---------------- compare process + period measurement ----------------
  int hi_run[3], hi_last[3], gap_run[3], gap_last[3];

  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 3; i++) begin
        check("pwm_model", i, int'(pwm_v[i]), int'(exp_pwm[i]));
        check("ps_model",  i, int'(ps_v[i]),  int'(exp_ps[i]));
        if (ps_v[i]) begin
          hi_last[i]  = hi_run[i];
          gap_last[i] = gap_run[i];
          hi_run[i]   = int'(pwm_v[i]);
          gap_run[i]  = 1;
        end else begin
          hi_run[i]  += int'(pwm_v[i]);
          gap_run[i] += 1;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Waits for `count` period_start strobes on DUT idx, each bounded.
  task automatic wait_ps(int idx, int count);
    for (int k = 0; k < count; k++) begin
      automatic bit found = 1'b0;
      for (int c = 0; c < per_of(idx) + 8; c++) begin
        @(negedge clk);
        #1;
        if (ps_v[idx]) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) begin
        check("ps_timeout", idx, 0, 1);
        return;
      end
    end
  endtask

  // ---------------- stimulus: default-parameter instance ----------------
  task automatic run_a();
    step(2);
    check("rst_pwm", 0, int'(pwm_a), 0);
    check("rst_ps",  0, int'(ps_a),  0);
    rst_a = 1'b0;
    wait_ps(0, 1);
    check("ps_aligned_high", 0, int'(pwm_a), 1);
    wait_ps(0, 2);
    check("hi_25",    0, hi_last[0], 25);
    check("gap_25",   0, gap_last[0], 4096);
    check("low_25",   0, gap_last[0] - hi_last[0], 4071);
    pw_a = 12'd0;
    wait_ps(0, 2);
    check("hi_0",     0, hi_last[0], 0);
    check("gap_0",    0, gap_last[0], 4096);
    pw_a = 12'd4095;
    wait_ps(0, 2);
    check("hi_4095",  0, hi_last[0], 4095);
    check("low_4095", 0, gap_last[0] - hi_last[0], 1);
    // Mid-period change: sampled 25 now, switch to 100 at count 10.
    pw_a = 12'd25;
    wait_ps(0, 1);
    step(9);
    pw_a = 12'd100;
    wait_ps(0, 1);
    check("hi_keep_25", 0, hi_last[0], 25);
    wait_ps(0, 1);
    check("hi_new_100", 0, hi_last[0], 100);
    // Reset at count 12 for two clocks.
    pw_a = 12'd25;
    wait_ps(0, 1);
    step(11);
    rst_a = 1'b1;
    step(1);
    check("midrst_pwm", 0, int'(pwm_a), 0);
    check("midrst_ps",  0, int'(ps_a),  0);
    step(1);
    check("midrst_pwm2", 0, int'(pwm_a), 0);
    rst_a = 1'b0;
    wait_ps(0, 1);
    check("post_rst_high", 0, int'(pwm_a), 1);
    wait_ps(0, 1);
    check("post_rst_hi",  0, hi_last[0], 25);
    check("post_rst_gap", 0, gap_last[0], 4096);
    // Random widths, changed at random points mid-period.
    repeat (3) begin
      pw_a = 12'($urandom_range(0, 4095));
      step($urandom_range(1, 2000));
      pw_a = 12'($urandom_range(0, 4095));
      wait_ps(0, 1);
    end
  endtask

  // ---------------- stimulus: PERIOD=100 instance ----------------
  task automatic run_b();
    step(2);
    rst_b = 1'b0;
    wait_ps(1, 3);
    check("sat_hi",  1, hi_last[1], 100);
    check("sat_gap", 1, gap_last[1], 100);
    pw_b = 12'd40;
    wait_ps(1, 2);
    check("hi_40",  1, hi_last[1], 40);
    check("low_40", 1, gap_last[1] - hi_last[1], 60);
    repeat (60) begin
      pw_b = 12'($urandom_range(0, 160));
      step($urandom_range(0, 150));
      if ($urandom_range(0, 9) == 0) begin
        rst_b = 1'b1;
        step($urandom_range(1, 3));
        rst_b = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus: INVERT=1 instance ----------------
  task automatic run_c();
    step(2);
    check("inv_rst_pwm", 2, int'(pwm_c), 1);
    check("inv_rst_ps",  2, int'(ps_c),  0);
    rst_c = 1'b0;
    wait_ps(2, 1);
    check("inv_first_low", 2, int'(pwm_c), 0);
    wait_ps(2, 2);
    check("inv_hi",  2, hi_last[2], 4071);
    check("inv_low", 2, gap_last[2] - hi_last[2], 25);
    check("inv_gap", 2, gap_last[2], 4096);
  endtask

  // ---------------- main + report ----------------
  initial begin
    fork
      run_a();
      run_b();
      run_c();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #950000;
    check("watchdog", 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
